// File: rtl/iob_uart_fifo_core.sv
// UART core: TX/RX serialisers with runtime parity/stop selection, per-direction
// FIFOs, RTS/CTS flow control and sticky {overrun, frame, parity} error flags.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle; TX waits for data+enable+CTS, RX waits for 1->0
// S_START  | start bit (RX: half-bit wait, false-start check)
// S_DATA   | DATA_W data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | stop bit(s); RX samples only the first one
module iob_uart_fifo_core #(
  parameter int DATA_W      = 8,
  parameter int FIFO_ADDR_W = 4,
  parameter int DIV_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   rst_soft_i,
  input  logic                   tx_en_i,
  input  logic                   rx_en_i,
  input  logic [DIV_W-1:0]       bit_duration_i,
  input  logic                   parity_en_i,
  input  logic                   parity_odd_i,
  input  logic                   stop2_i,
  input  logic [DATA_W-1:0]      tx_data_i,
  input  logic                   tx_write_i,
  output logic                   tx_full_o,
  output logic [FIFO_ADDR_W:0]   tx_level_o,
  output logic                   tx_busy_o,
  output logic [DATA_W-1:0]      rx_data_o,
  input  logic                   rx_read_i,
  output logic                   rx_empty_o,
  output logic [FIFO_ADDR_W:0]   rx_level_o,
  output logic [2:0]             err_o,
  input  logic                   err_clr_i,
  input  logic                   rxd_i,
  output logic                   txd_o,
  input  logic                   cts_i,
  output logic                   rts_o
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int LVL_W = FIFO_ADDR_W + 1;
  localparam int BIT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  logic clr;
  assign clr = !rst_n_i || rst_soft_i;

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (bit_duration_i < DIV_W'(2)) ? DIV_W'(2) : bit_duration_i;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0]      tx_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] tx_wr_q, tx_rd_q;
  logic [LVL_W-1:0]       tx_lvl_q;
  logic                   tx_empty, tx_full, tx_pop, tx_pop_ok, tx_push_ok;

  assign tx_empty   = (tx_lvl_q == '0);
  assign tx_full    = (tx_lvl_q == LVL_W'(DEPTH));
  assign tx_pop_ok  = tx_pop && !tx_empty;
  assign tx_push_ok = tx_write_i && (!tx_full || tx_pop_ok);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop_ok)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push_ok && !tx_pop_ok)      tx_lvl_q <= tx_lvl_q + 1'b1;
      else if (!tx_push_ok && tx_pop_ok) tx_lvl_q <= tx_lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr && tx_push_ok) tx_mem[tx_wr_q] <= tx_data_i;
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0]      rx_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] rx_wr_q, rx_rd_q;
  logic [LVL_W-1:0]       rx_lvl_q;
  logic                   rx_empty, rx_full, rx_push, rx_pop_ok, rx_push_ok, rx_ovr;
  logic [DATA_W-1:0]      rx_push_data;

  assign rx_empty   = (rx_lvl_q == '0);
  assign rx_full    = (rx_lvl_q == LVL_W'(DEPTH));
  assign rx_pop_ok  = rx_read_i && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);
  assign rx_ovr     = rx_push && rx_full && !rx_pop_ok;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop_ok)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push_ok && !rx_pop_ok)      rx_lvl_q <= rx_lvl_q + 1'b1;
      else if (!rx_push_ok && rx_pop_ok) rx_lvl_q <= rx_lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr && rx_push_ok) rx_mem[rx_wr_q] <= rx_push_data;
  end

  // ---------------- synchronisers ----------------
  logic [1:0] cts_sync_q, rx_sync_q;
  logic       rxd_prev_q;
  logic       cts_s, rxd_s;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      cts_sync_q <= 2'b00;
      rx_sync_q  <= 2'b11;
      rxd_prev_q <= 1'b1;
    end else begin
      cts_sync_q <= {cts_sync_q[0], cts_i};
      rx_sync_q  <= {rx_sync_q[0], rxd_i};
      rxd_prev_q <= rxd_s;
    end
  end

  assign cts_s = cts_sync_q[1];
  assign rxd_s = rx_sync_q[1];

  // ---------------- TX FSM ----------------
  uart_state_e       tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic              tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
  logic              tx_stop2_q, tx_stop2_d, tx_second_q, tx_second_d;
  logic              txd_q, txd_d, tx_busy_q, tx_busy_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_sh_d     = tx_sh_q;
    tx_bit_d    = tx_bit_q;
    tx_par_d    = tx_par_q;
    tx_pen_d    = tx_pen_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    tx_pop      = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        if (tx_en_i && !tx_empty && cts_s) begin
          tx_state_d = S_START;
          tx_pop     = 1'b1;
          tx_div_d   = div_eff;
          tx_cnt_d   = div_eff - DIV_W'(1);
          tx_sh_d    = tx_mem[tx_rd_q];
          tx_par_d   = (^tx_mem[tx_rd_q]) ^ parity_odd_i;
          tx_pen_d   = parity_en_i;
          tx_stop2_d = stop2_i;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = tx_div_q - DIV_W'(1);
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = tx_div_q - DIV_W'(1);
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
            tx_state_d  = tx_pen_q ? S_PARITY : S_STOP;
            tx_second_d = 1'b0;
          end else tx_bit_d = tx_bit_q + 1'b1;
        end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      end
      S_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d  = S_STOP;
          tx_cnt_d    = tx_div_q - DIV_W'(1);
          tx_second_d = 1'b0;
        end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          if (tx_stop2_q && !tx_second_q) begin
            tx_second_d = 1'b1;
            tx_cnt_d    = tx_div_q - DIV_W'(1);
          end else tx_state_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line level and busy follow the current state, so both lag it by one cycle.
  always_comb begin
    txd_d = 1'b1;
    unique case (tx_state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = tx_sh_q[0];
      S_PARITY: txd_d = tx_par_q;
      default:  txd_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_q != S_IDLE) || !tx_empty;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= DIV_W'(2);
      tx_sh_q     <= '0;
      tx_bit_q    <= '0;
      tx_par_q    <= 1'b0;
      tx_pen_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
      txd_q       <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_sh_q     <= tx_sh_d;
      tx_bit_q    <= tx_bit_d;
      tx_par_q    <= tx_par_d;
      tx_pen_q    <= tx_pen_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_second_q <= tx_second_d;
      txd_q       <= txd_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_e       rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic              rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic              set_ferr, set_perr;

  assign rx_push_data = rx_sh_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    if (!rx_en_i) begin
      rx_state_d = S_IDLE;
    end else begin
      unique case (rx_state_q)
        S_IDLE: begin
          if (rxd_prev_q && !rxd_s) begin
            rx_state_d = S_START;
            rx_div_d   = div_eff;
            rx_cnt_d   = (div_eff >> 1) - DIV_W'(1);
            rx_pen_d   = parity_en_i;
            rx_odd_d   = parity_odd_i;
            rx_perr_d  = 1'b0;
          end
        end
        S_START: begin
          if (rx_cnt_q == '0) begin
            if (rxd_s) rx_state_d = S_IDLE;
            else begin
              rx_state_d = S_DATA;
              rx_cnt_d   = rx_div_q - DIV_W'(1);
              rx_bit_d   = '0;
            end
          end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
        S_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_d = rx_div_q - DIV_W'(1);
            rx_sh_d  = {rxd_s, rx_sh_q[DATA_W-1:1]};
            if (rx_bit_q == BIT_W'(DATA_W - 1)) rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
            else rx_bit_d = rx_bit_q + 1'b1;
          end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
        S_PARITY: begin
          if (rx_cnt_q == '0) begin
            rx_perr_d  = rxd_s != ((^rx_sh_q) ^ rx_odd_q);
            rx_state_d = S_STOP;
            rx_cnt_d   = rx_div_q - DIV_W'(1);
          end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
        S_STOP: begin
          // Errors are reported together with the push of the offending byte.
          if (rx_cnt_q == '0) begin
            rx_push    = 1'b1;
            set_ferr   = !rxd_s;
            set_perr   = rx_perr_q;
            rx_state_d = S_IDLE;
          end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(2);
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------- errors and flow control ----------------
  logic [2:0] err_q, err_d;
  logic       rts_q, rts_d;

  always_comb begin
    err_d = (err_clr_i ? 3'b000 : err_q) | {rx_ovr, set_ferr, set_perr};
    rts_d = rx_en_i && (rx_lvl_q <= LVL_W'(DEPTH - 2));
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      err_q <= 3'b000;
      rts_q <= 1'b0;
    end else begin
      err_q <= err_d;
      rts_q <= rts_d;
    end
  end

  assign tx_full_o  = tx_full;
  assign tx_level_o = tx_lvl_q;
  assign tx_busy_o  = tx_busy_q;
  assign rx_data_o  = rx_empty ? '0 : rx_mem[rx_rd_q];
  assign rx_empty_o = rx_empty;
  assign rx_level_o = rx_lvl_q;
  assign err_o      = err_q;
  assign txd_o      = txd_q;
  assign rts_o      = rts_q;

endmodule

// File: tb/tb_iob_uart_fifo_core.sv
// Directed self-checking bench for iob_uart_fifo_core (DATA_W=8, depth 16).
module tb_iob_uart_fifo_core;

  logic        clk_i = 1'b0;
  logic        rst_n_i, rst_soft_i, tx_en_i, rx_en_i;
  logic [15:0] bit_duration_i;
  logic        parity_en_i, parity_odd_i, stop2_i;
  logic [7:0]  tx_data_i;
  logic        tx_write_i, tx_full_o, tx_busy_o;
  logic [4:0]  tx_level_o, rx_level_o;
  logic [7:0]  rx_data_o;
  logic        rx_read_i, rx_empty_o;
  logic [2:0]  err_o;
  logic        err_clr_i, rxd_i, txd_o, cts_i, rts_o;
  logic        lb, rxd_drv;

  int checks = 0;
  int failures = 0;

  assign rxd_i = lb ? txd_o : rxd_drv;

  always #5 clk_i = ~clk_i;

  iob_uart_fifo_core #(.DATA_W(8), .FIFO_ADDR_W(4), .DIV_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rst_soft_i(rst_soft_i),
    .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .bit_duration_i(bit_duration_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .tx_data_i(tx_data_i), .tx_write_i(tx_write_i), .tx_full_o(tx_full_o),
    .tx_level_o(tx_level_o), .tx_busy_o(tx_busy_o), .rx_data_o(rx_data_o),
    .rx_read_i(rx_read_i), .rx_empty_o(rx_empty_o), .rx_level_o(rx_level_o),
    .err_o(err_o), .err_clr_i(err_clr_i), .rxd_i(rxd_i), .txd_o(txd_o),
    .cts_i(cts_i), .rts_o(rts_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push(input logic [7:0] d);
    tx_data_i  = d;
    tx_write_i = 1'b1;
    @(negedge clk_i);
    tx_write_i = 1'b0;
  endtask

  task automatic pop();
    rx_read_i = 1'b1;
    @(negedge clk_i);
    rx_read_i = 1'b0;
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  task automatic wait_rx_level(input string tag, input int lvl, input int max);
    for (int i = 0; i < max; i++) begin
      if (rx_level_o == 5'(lvl)) break;
      @(negedge clk_i);
    end
    chk(tag, rx_level_o, lvl);
  endtask

  task automatic wait_txd_low(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (txd_o == 1'b0) break;
      @(negedge clk_i);
    end
    chk(tag, txd_o, 0);
  endtask

  task automatic wait_tx_idle(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (tx_busy_o == 1'b0) break;
      @(negedge clk_i);
    end
    chk(tag, tx_busy_o, 0);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic pen, input logic pbit, input int div);
    rxd_drv = 1'b0;
    cyc(div);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      cyc(div);
    end
    if (pen) begin
      rxd_drv = pbit;
      cyc(div);
    end
    rxd_drv = 1'b1;
    cyc(div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame;
    int zeros, falls;
    logic prev;

    rst_n_i = 1'b0; rst_soft_i = 1'b0; tx_en_i = 1'b1; rx_en_i = 1'b1;
    bit_duration_i = 16'd4; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    tx_data_i = '0; tx_write_i = 1'b0; rx_read_i = 1'b0; err_clr_i = 1'b0;
    cts_i = 1'b1; lb = 1'b0; rxd_drv = 1'b1;
    cyc(3);

    chk("rst_txd", txd_o, 1);
    chk("rst_rts", rts_o, 0);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_full", tx_full_o, 0);
    chk("rst_rx_empty", rx_empty_o, 1);
    chk("rst_tx_level", tx_level_o, 0);
    chk("rst_rx_level", rx_level_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rx_data", rx_data_o, 0);

    rst_n_i = 1'b1;
    cyc(5);
    chk("rts_after_rst", rts_o, 1);

    // 1: 8N1 div=4, 0xA5 bit by bit
    frame = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    wait_txd_low("t1_start", 20);
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_bit%0d", i), txd_o, frame[i]);
      if (i < 9) cyc(4);
    end
    chk("t1_busy_in_stop", tx_busy_o, 1);
    cyc(3);
    chk("t1_busy_after", tx_busy_o, 0);
    chk("t1_txd_idle", txd_o, 1);
    cyc(10);

    // 2: loopback 8E2 div=8, 16 bytes
    lb = 1'b1; bit_duration_i = 16'd8; parity_en_i = 1'b1; parity_odd_i = 1'b0; stop2_i = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    wait_rx_level("t2_peak", 16, 3000);
    chk("t2_err", err_o, 0);
    wait_tx_idle("t2_tx_idle", 500);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_data%0d", i), rx_data_o, i);
      pop();
    end
    chk("t2_level_end", rx_level_o, 0);
    chk("t2_empty_end", rx_empty_o, 1);

    // 3: fill RX FIFO, then overrun
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    wait_rx_level("t3_lvl15", 15, 3000);
    cyc(1);
    chk("t3_rts_at15", rts_o, 0);
    wait_rx_level("t3_lvl16", 16, 500);
    chk("t3_err_before", err_o, 0);
    push(8'h30);
    wait_tx_idle("t3_tx_idle", 500);
    cyc(20);
    chk("t3_level", rx_level_o, 16);
    chk("t3_err_ovr", err_o, 3'b100);
    chk("t3_head", rx_data_o, 8'h20);
    chk("t3_rts", rts_o, 0);
    clr_err();
    chk("t3_err_clr", err_o, 0);
    pop();
    chk("t3_head_next", rx_data_o, 8'h21);
    for (int i = 0; i < 15; i++) pop();
    chk("t3_flushed", rx_level_o, 0);
    cyc(2);
    chk("t3_rts_back", rts_o, 1);

    // 4: odd-parity frame into even-parity receiver
    lb = 1'b0; parity_en_i = 1'b1; parity_odd_i = 1'b0; stop2_i = 1'b0; bit_duration_i = 16'd8;
    cyc(4);
    drive_frame(8'h55, 1'b1, 1'b1, 8);
    cyc(10);
    chk("t4_level", rx_level_o, 1);
    chk("t4_data", rx_data_o, 8'h55);
    chk("t4_err_par", err_o, 3'b001);
    clr_err();
    chk("t4_err_clr", err_o, 0);
    pop();

    // 5: one-cycle glitch at div=16, then a valid 8E1 frame
    bit_duration_i = 16'd16;
    rxd_drv = 1'b0;
    cyc(1);
    rxd_drv = 1'b1;
    cyc(40);
    chk("t5_no_push", rx_level_o, 0);
    chk("t5_no_err", err_o, 0);
    drive_frame(8'h3C, 1'b1, 1'b0, 16);
    cyc(10);
    chk("t5_frame_level", rx_level_o, 1);
    chk("t5_frame_data", rx_data_o, 8'h3C);
    chk("t5_frame_err", err_o, 0);
    pop();

    // TX FIFO full, dropped pushes, soft reset
    bit_duration_i = 16'd4; parity_en_i = 1'b0; stop2_i = 1'b0;
    cts_i = 1'b0;
    cyc(4);
    zeros = 0;
    for (int i = 0; i < 18; i++) begin
      push(8'hFF);
      if (txd_o == 1'b0) zeros++;
    end
    chk("full_level", tx_level_o, 16);
    chk("full_flag", tx_full_o, 1);
    rst_soft_i = 1'b1;
    cyc(1);
    rst_soft_i = 1'b0;
    chk("soft_level", tx_level_o, 0);
    chk("soft_full", tx_full_o, 0);

    // 6: CTS hold, release, then hard reset mid-frame
    for (int i = 0; i < 3; i++) push(8'hFF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (txd_o == 1'b0) zeros++;
    end
    chk("t6_cts_hold_txd", zeros, 0);
    chk("t6_queued", tx_level_o, 3);
    cts_i = 1'b1;
    falls = 0;
    prev = txd_o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (prev && !txd_o) falls++;
      prev = txd_o;
    end
    chk("t6_frames", falls, 3);
    chk("t6_level_done", tx_level_o, 0);
    chk("t6_busy_done", tx_busy_o, 0);
    push(8'h00);
    push(8'h00);
    wait_txd_low("t6_mid_start", 20);
    cyc(10);
    rst_n_i = 1'b0;
    cyc(1);
    chk("t6_rst_txd", txd_o, 1);
    chk("t6_rst_level", tx_level_o, 0);
    chk("t6_rst_busy", tx_busy_o, 0);
    rst_n_i = 1'b1;
    cyc(5);
    chk("t6_post_txd", txd_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
